// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin arbiter that lends a shared 2-bit burst counter to one of four
//   requesters at a time. A grant lasts until the owner drops its request or
//   the burst limit is reached. Handover to the next requester happens on the
//   same edge, so there is no idle cycle between grants.
//
// Ports
//   clk        : single clock, all state on rising edge
//   reset      : synchronous, active-high
//   req[3:0]   : request lines, req[i]=1 means requester i wants the counter
//   grant[3:0] : one-hot grant or all-zero (registered)
//   grant_id   : index of the granted requester, valid while busy=1 (registered)
//   count_out  : cycles elapsed in the current grant, 0..MAX_BURST-1 (registered)
//   busy       : high whenever a grant is active
//   burst_done : high in the last cycle of a grant that reaches the burst limit
module counter_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic [1:0] count_out,
    output logic       busy,
    output logic       burst_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [1:0] LAST     = 2'(MAX_BURST - 1);

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_grant_id;
    logic [1:0] r_count;
    logic [3:0] r_grant;

    logic       w_end;
    logic [1:0] w_ptr_nxt;
    logic [1:0] w_arb_ptr;
    logic [2:0] w_pick;

    // Returns {found, index}: first set bit of r scanning upward from p (mod 4).
    // The scan runs backwards so the lowest offset from p is written last.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // A grant ends on release or on the limit; both together still end it once.
    assign w_end     = !req[r_grant_id] || (r_count == LAST);
    assign w_ptr_nxt = r_grant_id + 2'd1;
    // At grant end arbitration already uses the advanced pointer, which puts
    // the outgoing owner at lowest priority.
    assign w_arb_ptr = (r_state == ST_GRANT) ? w_ptr_nxt : r_ptr;
    assign w_pick    = pick(req, w_arb_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'd0;
            r_count    <= 2'd0;
            r_ptr      <= 2'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_pick[2]) begin
                r_state    <= ST_GRANT;
                r_grant    <= 4'b0001 << w_pick[1:0];
                r_grant_id <= w_pick[1:0];
                r_count    <= 2'd0;
            end
        end else begin
            if (!w_end) begin
                r_count <= r_count + 2'd1;
            end else begin
                r_ptr   <= w_ptr_nxt;
                r_count <= 2'd0;
                if (w_pick[2]) begin
                    r_grant    <= 4'b0001 << w_pick[1:0];
                    r_grant_id <= w_pick[1:0];
                end else begin
                    r_state <= ST_IDLE;
                    r_grant <= 4'b0000;
                end
            end
        end
    end

    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign count_out  = r_count;
    assign busy       = (r_state == ST_GRANT);
    assign burst_done = busy && (r_count == LAST);

endmodule
